// File: rtl/sum_sched.sv
// Two-requester scheduler for a shared lo+hi sum datapath: arbitrates, issues one
// operand pair per transaction to the external datapath and returns the captured sum.
module sum_sched #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         async_reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [49:0]  req0_lo,
    input  logic [49:0]  req0_hi,
    input  logic [49:0]  req1_lo,
    input  logic [49:0]  req1_hi,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [50:0]  rsp_sum,
    output logic [2:0]   rsp_seq,
    output logic         err,
    output logic [1:0]   dp_ena,
    output logic [99:0]  dp_data,
    input  logic [3:0]   dp_q,
    input  logic [99:0]  dp_q_out
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state;
    logic   last_grant;
    logic   cap_id;
    logic   any_valid;
    logic   grant_id;
    logic   accept;

    // Under contention the round-robin mode favours whoever did not win last time.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = RR_EN ? ~last_grant : 1'b0;
        end else begin
            grant_id = req1_valid;
        end
        accept = (state == IDLE) && !async_reset && any_valid;
    end

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    // dp_data doubles as the captured operand register; it is only rewritten on accept.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cap_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_seq    <= '0;
            err        <= 1'b0;
            dp_ena     <= 2'b00;
            dp_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        dp_data    <= grant_id ? {req1_hi, req1_lo} : {req0_hi, req0_lo};
                        cap_id     <= grant_id;
                        last_grant <= grant_id;
                        dp_ena     <= 2'b11;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_sum   <= dp_q_out[50:0];
                    rsp_seq   <= dp_q[2:0];
                    rsp_id    <= cap_id;
                    rsp_valid <= 1'b1;
                    dp_ena    <= 2'b00;
                    if ((|dp_q_out[99:51]) || dp_q[3]) begin
                        err <= 1'b1;
                    end
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
